merge2_reader: RTL

- Read side of a pair of synchronous FIFOs in the merge-sort datapath.
- Each FIFO holds one ascending-sorted run of 2**LOG2_RUN words. The block peeks both heads, pops the smaller, and emits one merged ascending run of 2*2**LOG2_RUN words through a registered valid/ready output stage.
- Connects directly to the FIFO empty / unregistered-head / rd_en interface.

---
 rtl/merge2_reader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/merge2_reader.sv
`default_nettype none
// ============================================================================
// merge2_reader: pops the smaller head of two sorted FIFO runs and emits one
// merged ascending run through a registered valid/ready output stage.
// Revision: 1.0 - initial release
// ============================================================================
module merge2_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int LOG2_RUN   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic                  a_empty,
   input  logic [DATA_WIDTH-1:0] a_head,
   output logic                  a_rd_en,
   input  logic                  b_empty,
   input  logic [DATA_WIDTH-1:0] b_head,
   output logic                  b_rd_en,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int c_cnt_w = LOG2_RUN + 1;
   localparam logic [c_cnt_w-1:0] c_run_m1 = c_cnt_w'((2 ** LOG2_RUN) - 1);

   localparam logic [2:0] c_idle    = 3'd0;
   localparam logic [2:0] c_merge   = 3'd1;
   localparam logic [2:0] c_drain_a = 3'd2;
   localparam logic [2:0] c_drain_b = 3'd3;
   localparam logic [2:0] c_flush   = 3'd4;
   localparam logic [2:0] c_done    = 3'd5;

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt_a;
   logic [c_cnt_w-1:0] r_cnt_b;
   logic               w_can_load;
   logic               w_pop_a;
   logic               w_pop_b;
   logic               w_final;

   assign w_can_load = !out_valid || out_ready;

   // Leaving a MERGE/DRAIN state on the pop that fills a counter guarantees
   // a full FIFO run is never popped again.
   always_comb begin
      w_pop_a     = 1'b0;
      w_pop_b     = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         c_idle: begin
            if (start) w_state_nxt = c_merge;
         end
         c_merge: begin
            if (w_can_load && !a_empty && !b_empty) begin
               if (a_head <= b_head) begin
                  w_pop_a = 1'b1;
                  if (r_cnt_a == c_run_m1) w_state_nxt = c_drain_b;
               end else begin
                  w_pop_b = 1'b1;
                  if (r_cnt_b == c_run_m1) w_state_nxt = c_drain_a;
               end
            end
         end
         c_drain_a: begin
            if (w_can_load && !a_empty) begin
               w_pop_a = 1'b1;
               if (r_cnt_a == c_run_m1) w_state_nxt = c_flush;
            end
         end
         c_drain_b: begin
            if (w_can_load && !b_empty) begin
               w_pop_b = 1'b1;
               if (r_cnt_b == c_run_m1) w_state_nxt = c_flush;
            end
         end
         c_flush: begin
            if (out_valid && out_ready && out_last) w_state_nxt = c_done;
         end
         c_done: begin
            w_state_nxt = c_idle;
         end
         default: begin
            w_state_nxt = c_idle;
         end
      endcase
   end

   // The only pop that enters FLUSH is the one completing the whole merged run.
   assign w_final = (w_pop_a || w_pop_b) && (w_state_nxt == c_flush);

   assign a_rd_en = w_pop_a;
   assign b_rd_en = w_pop_b;
   assign busy    = (r_state != c_idle);
   assign done    = (r_state == c_done);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= c_idle;
         r_cnt_a   <= '0;
         r_cnt_b   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == c_idle && start) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
         end else begin
            if (w_pop_a) r_cnt_a <= r_cnt_a + 1'b1;
            if (w_pop_b) r_cnt_b <= r_cnt_b + 1'b1;
         end
         if (w_pop_a || w_pop_b) begin
            out_data  <= w_pop_a ? a_head : b_head;
            out_valid <= 1'b1;
            out_last  <= w_final;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
